// File: rtl/mips_pkg.sv
// Shared branch-unit encodings: branch op codes, comparator codes, PC step and
// the resolved-result record carried through the output and skid registers.
package mips_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLEZ = 3'b011,
    BR_BGTZ = 3'b100,
    BR_BLTZ = 3'b101,
    BR_BGEZ = 3'b110,
    BR_RSVD = 3'b111
  } br_op_e;

  typedef enum logic [1:0] {
    CMP_EQ  = 2'b00,
    CMP_LT  = 2'b01,
    CMP_GT  = 2'b10,
    CMP_ILL = 2'b11
  } cmp_res_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic        op_nz;
  } br_res_t;

  // Word offset to byte offset: sign-extend, then shift left by two.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/br_eval.sv
// Combinational branch evaluator: direction, target address and illegal-input
// detection for one branch request.
module br_eval
  import mips_pkg::*;
(
  input  logic [2:0]  br_op_i,
  input  logic [1:0]  cmp_res_i,
  input  logic        rs_sign_i,
  input  logic        rs_zero_i,
  input  logic [31:0] pc_i,
  input  logic [15:0] imm_i,
  output logic        taken_o,
  output logic [31:0] target_o,
  output logic        illegal_o
);

  br_op_e   op_s;
  cmp_res_e cmp_s;
  logic     dir_s;
  logic     illegal_s;

  assign op_s  = br_op_e'(br_op_i);
  assign cmp_s = cmp_res_e'(cmp_res_i);

  // Raw direction per op, plus illegal combinations.
  always_comb begin
    dir_s     = 1'b0;
    illegal_s = 1'b0;
    case (op_s)
      BR_BEQ: begin
        dir_s     = (cmp_s == CMP_EQ);
        illegal_s = (cmp_s == CMP_ILL);
      end
      BR_BNE: begin
        dir_s     = (cmp_s == CMP_LT) || (cmp_s == CMP_GT);
        illegal_s = (cmp_s == CMP_ILL);
      end
      BR_BLEZ: dir_s = rs_sign_i | rs_zero_i;
      BR_BGTZ: dir_s = ~rs_sign_i & ~rs_zero_i;
      BR_BLTZ: dir_s = rs_sign_i;
      BR_BGEZ: dir_s = ~rs_sign_i;
      BR_RSVD: illegal_s = 1'b1;
      default: dir_s = 1'b0;
    endcase
  end

  assign taken_o   = dir_s & ~illegal_s;
  assign illegal_o = illegal_s;
  assign target_o  = pc_i + PC_STEP + branch_offset(imm_i);

endmodule

// File: rtl/br_resolve.sv
// Branch resolution stage: evaluates one request per cycle into an output
// register backed by a 1-entry skid, with sticky error and saturating stats.
module br_resolve
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       br_op,
  input  logic [1:0]       cmp_res,
  input  logic             rs_sign,
  input  logic             rs_zero,
  input  logic [31:0]      pc,
  input  logic [15:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [31:0]      target,
  output logic             flush,
  output logic             err,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic        eval_taken_s;
  logic [31:0] eval_target_s;
  logic        eval_illegal_s;
  br_res_t     in_res_s;

  br_res_t          out_q, out_d, skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_full_q, skid_full_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic accept_s, out_fire_s, out_free_s;

  br_eval u_br_eval (
    .br_op_i   (br_op),
    .cmp_res_i (cmp_res),
    .rs_sign_i (rs_sign),
    .rs_zero_i (rs_zero),
    .pc_i      (pc),
    .imm_i     (imm),
    .taken_o   (eval_taken_s),
    .target_o  (eval_target_s),
    .illegal_o (eval_illegal_s)
  );

  assign in_res_s   = {eval_taken_s, eval_target_s, (br_op != BR_NONE)};
  assign in_ready   = ~skid_full_q;
  assign accept_s   = in_valid & ~skid_full_q;
  assign out_fire_s = out_valid_q & out_ready;
  assign out_free_s = ~out_valid_q | out_ready;

  // Output/skid steering; a full skid always refills the output before new input.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    if (out_free_s) begin
      if (skid_full_q) begin
        out_d       = skid_q;
        out_valid_d = 1'b1;
        skid_full_d = 1'b0;
      end else if (accept_s) begin
        out_d       = in_res_s;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_d      = in_res_s;
        skid_full_d = 1'b1;
      end else begin
        skid_d      = skid_q;
      end
    end
  end

  // Sticky error and saturating statistics counters.
  always_comb begin
    err_d       = err_q | (accept_s & eval_illegal_s);
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (out_fire_s && out_q.op_nz && (br_cnt_q != CNT_MAX)) begin
      br_cnt_d = br_cnt_q + CNT_ONE;
    end else begin
      br_cnt_d = br_cnt_q;
    end
    if (out_fire_s && out_q.taken && (taken_cnt_q != CNT_MAX)) begin
      taken_cnt_d = taken_cnt_q + CNT_ONE;
    end else begin
      taken_cnt_d = taken_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      err_q       <= 1'b0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
      err_q       <= err_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign taken     = out_q.taken;
  assign target    = out_q.target;
  assign err       = err_q;
  assign br_cnt    = br_cnt_q;
  assign taken_cnt = taken_cnt_q;
  // Gated by rst so a reset during a stall cannot emit a flush.
  assign flush     = out_valid_q & out_ready & out_q.taken & ~rst;

endmodule

// File: doc/br_resolve.md
BR_RESOLVE -- requirements
Module: br_resolve

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the branch and taken statistics counters.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  upstream offers a branch request.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 br_op  input  3  operation: 000 NONE, 001 BEQ, 010 BNE, 011 BLEZ, 100 BGTZ, 101 BLTZ, 110 BGEZ, 111 reserved.
REQ-007 cmp_res  input  2  comparator code for rs vs rt: 00 equal, 10 rs>rt, 01 rs<rt, 11 illegal.
REQ-008 rs_sign  input  1  rs[31].
REQ-009 rs_zero  input  1  rs == 0.
REQ-010 pc  input  32  address of the branch instruction.
REQ-011 imm  input  16  branch offset in words, signed.
REQ-012 out_valid  output  1  a resolved result is presented.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 taken  output  1  resolved branch direction.
REQ-015 target  output  32  branch target address.
REQ-016 flush  output  1  one-cycle pulse on the handshake of a taken result.
REQ-017 err  output  1  sticky illegal-input flag.
REQ-018 br_cnt, taken_cnt  output  CNT_W each  count of accepted non-NONE results, and of taken results.

Function
REQ-019 An input handshake occurs when in_valid & in_ready; the resolved result SHALL appear on out_valid exactly 1 cycle later if the output register is free.
REQ-020 Direction:
- BEQ: cmp_res==00.
- BNE: cmp_res is 01 or 10.
- BLEZ: rs_sign|rs_zero.
- BGTZ: !rs_sign&!rs_zero.
- BLTZ: rs_sign.
- BGEZ: !rs_sign.
- NONE and reserved: not taken.
REQ-021 target SHALL be pc + 4 + sign_extend(imm)<<2, computed modulo 2^32 with no overflow indication; it is valid for all ops.
REQ-022 cmp_res==11 with BEQ/BNE, or br_op==111, SHALL force taken=0 and set err on the accepting cycle; err SHALL remain set until reset.
REQ-023 Output SHALL hold all fields stable while out_valid & !out_ready.
REQ-024 A 1-entry skid register SHALL capture a result accepted while the output register is stalled.
REQ-025 in_ready SHALL be !skid_full and SHALL depend only on registered state.
REQ-026 When the output register drains, the skid entry SHALL move to it in the same cycle; order SHALL be strictly preserved.
REQ-027 When the output drains, the skid is empty and an input is accepted in the same cycle, the new result SHALL load the output register directly.
REQ-028 flush SHALL equal out_valid & out_ready & taken, combinationally from registered fields.
REQ-029 On each output handshake with op != NONE, br_cnt SHALL increment; if taken, taken_cnt SHALL increment.
REQ-030 Both counters SHALL saturate at all-ones.

Reset
REQ-031 While rst is high, out_valid, taken, flush, err, the skid entry, br_cnt and taken_cnt SHALL be 0, target SHALL be 0, and in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-032 Reset asserted mid-stall SHALL discard both buffered results without producing flush.

Structure
REQ-033 br_op encodings, cmp_res codes and the constant 4 SHALL live in shared package mips_pkg.
REQ-034 The direction and target logic SHALL be one sub-module, br_eval, instantiated once at the input and feeding both the output register and the skid register.

Verification
REQ-035 BEQ, cmp_res=00, pc=0x00400000, imm=0x0003, out_ready=1 -> next cycle out_valid=1, taken=1, target=0x00400010, flush=1, br_cnt=1.
REQ-036 BGTZ, rs_sign=0, rs_zero=1 -> taken=0, flush=0; BLTZ with imm=0xFFFF, pc=0x0 -> target=0x00000000.
REQ-037 pc=0xFFFFFFFC, imm=0x0000 -> target=0x00000000 (wrap-around).
REQ-038 Hold out_ready=0 and send 2 requests -> second captured in skid, in_ready=0. Release -> both emerge in order on consecutive cycles.
REQ-039 BNE with cmp_res=11 -> taken=0, err=1, which persists across later legal requests until rst.
REQ-040 Preload br_cnt to all-ones via CNT_W=2 and 5 taken branches -> br_cnt=3, taken_cnt=3; assert rst mid-stall -> out_valid=0, counters 0.
